// File: rtl/cla_serial_adder_ctrl_if.sv
// cla_serial_adder_ctrl_if: request/result bundle for the serial CLA adder controller.
//   start, a, b, cin (and sub when CLA_SUB_EN is defined) go from requester to controller.
//   busy, done, sum, cout go from controller back to requester.
//   master modport = requester side, slave modport = controller side.
interface cla_serial_adder_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef CLA_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CLA_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/cla_serial_adder_ctrl.sv
// cla_serial_adder_ctrl: WIDTH-bit adder built from one 2-bit carry-lookahead slice
// stepped over WIDTH/2 cycles, least significant digit first.
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      slave side of cla_serial_adder_ctrl_if:
//            start/a/b/cin in, busy/done/sum/cout out
// Optional macro CLA_SUB_EN adds the sub input (a - b via ~b and forced carry-in).
module cla_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   cla_serial_adder_ctrl_if.slave bus
);
   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("cla_serial_adder_ctrl: WIDTH must be even and >= 2");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, nxt;
   logic [WIDTH-1:0] ra, rb, res, sum_r;
   logic [CW-1:0]    cnt;
   logic             carry, cout_r;
   logic             accept, last;
   logic [WIDTH-1:0] b_sel;
   logic             c_sel;
   logic [1:0]       g, p, dsum;
   logic             c1, dco;
   logic [WIDTH+1:0] res_ext;

`ifdef CLA_SUB_EN
   assign b_sel = bus.sub ? ~bus.b : bus.b;
   assign c_sel = bus.sub | bus.cin;
`else
   assign b_sel = bus.b;
   assign c_sel = bus.cin;
`endif

   // 2-bit lookahead slice on the low digit of the operand shift registers
   assign g    = ra[1:0] & rb[1:0];
   assign p    = ra[1:0] ^ rb[1:0];
   assign c1   = g[0] | (p[0] & carry);
   assign dco  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
   assign dsum = p ^ {c1, carry};

   // new digit enters at the top; slicing the extended vector keeps WIDTH=2 legal
   assign res_ext = {dsum, res};
   assign accept  = bus.start && state != RUN;
   assign last    = cnt == CW'(N - 1);

   always_comb begin
      nxt = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         carry  <= 1'b0;
         ra     <= '0;
         rb     <= '0;
         res    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            ra    <= bus.a;
            rb    <= b_sel;
            carry <= c_sel;
            cnt   <= '0;
         end else if (state == RUN) begin
            ra    <= ra >> 2;
            rb    <= rb >> 2;
            res   <= res_ext[WIDTH+1:2];
            carry <= dco;
            cnt   <= cnt + 1'b1;
            if (last) begin
               sum_r  <= res_ext[WIDTH+1:2];
               cout_r <= dco;
            end
         end
      end
   end

   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// tb_cla_serial_adder_ctrl: directed scoreboard bench for an 8-bit and a 2-bit controller.
module tb_cla_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [8:0] q8[$];
   logic [2:0] q2[$];

   always #5 clk = ~clk;

   cla_serial_adder_ctrl_if #(.WIDTH(8)) b8 ();
   cla_serial_adder_ctrl_if #(.WIDTH(2)) b2 ();

   cla_serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   cla_serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic os, input bit poke);
      logic [8:0] e;
      e = {1'b0, oa} + {1'b0, (os ? ~ob : ob)} + {8'd0, (os ? 1'b1 : oc)};
      q8.push_back(e);
      b8.start = 1'b1; b8.a = oa; b8.b = ob; b8.cin = oc;
`ifdef CLA_SUB_EN
      b8.sub = os;
`endif
      tick();
      b8.start = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
         check("busy8", b8.busy, 1);
         check("nodone8", b8.done, 0);
         if (poke && i == 1) begin
            b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1;
         end else b8.start = 1'b0;
         tick();
      end
      b8.start = 1'b0;
      check("done8", b8.done, 1);
      check("notbusy8", b8.busy, 0);
      if (q8.size() == 0) check("q8empty", 0, 1);
      else begin
         e = q8.pop_front();
         check("sum8", b8.sum, e[7:0]);
         check("cout8", b8.cout, e[8]);
      end
   endtask

   task automatic after_done();
      logic [7:0] s;
      logic       c;
      s = b8.sum; c = b8.cout;
      tick();
      check("pulse8", b8.done, 0);
      check("holdsum8", b8.sum, s);
      check("holdcout8", b8.cout, c);
   endtask

   task automatic do_op2(input logic [1:0] oa, input logic [1:0] ob, input logic oc);
      logic [2:0] e;
      e = {1'b0, oa} + {1'b0, ob} + {2'd0, oc};
      q2.push_back(e);
      b2.start = 1'b1; b2.a = oa; b2.b = ob; b2.cin = oc;
      tick();
      b2.start = 1'b0; b2.a = ~oa;
      check("busy2", b2.busy, 1);
      tick();
      check("done2", b2.done, 1);
      e = q2.pop_front();
      check("sum2", b2.sum, e[1:0]);
      check("cout2", b2.cout, e[2]);
      tick();
      check("pulse2", b2.done, 0);
   endtask

   initial begin
      b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
      b2.start = 1'b0; b2.a = '0; b2.b = '0; b2.cin = 1'b0;
`ifdef CLA_SUB_EN
      b8.sub = 1'b0; b2.sub = 1'b0;
`endif
      b8.start = 1'b1;
      tick(); tick();
      b8.start = 1'b0;
      rst = 1'b0;
      check("rst_busy", b8.busy, 0);
      check("rst_done", b8.done, 0);
      check("rst_sum", b8.sum, 0);
      check("rst_cout", b8.cout, 0);
      check("rst_busy2", b2.busy, 0);
      check("rst_sum2", b2.sum, 0);
      tick();
      check("idle_busy", b8.busy, 0);

      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      after_done();
      do_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1);
      after_done();

      do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
      do_op(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
      after_done();

      b8.start = 1'b1; b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0;
      tick();
      b8.start = 1'b0;
      tick();
      rst = 1'b1; b8.start = 1'b1;
      tick();
      check("abort_busy", b8.busy, 0);
      check("abort_done", b8.done, 0);
      check("abort_sum", b8.sum, 0);
      check("abort_cout", b8.cout, 0);
      rst = 1'b0; b8.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_quiet", {14'd0, b8.busy, b8.done}, 0);
      end
      do_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b0);
      after_done();

`ifdef CLA_SUB_EN
      do_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
      after_done();
      do_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
      after_done();
      do_op(8'h40, 8'h40, 1'b0, 1'b0, 1'b0);
      after_done();
`endif

      for (int i = 0; i < 6; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
         after_done();
      end

      do_op2(2'b11, 2'b01, 1'b1);
      for (int i = 0; i < 32; i++) do_op2(i[1:0], i[3:2], i[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
